// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: state enum, opcodes,
// datapath mux selects and the func3-based legality/size helpers.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] RES_ALUOUT = 3'b000;
  localparam logic [2:0] RES_MEM    = 3'b001;
  localparam logic [2:0] RES_PC4    = 3'b010;
  localparam logic [2:0] RES_IMM    = 3'b011;
  localparam logic [2:0] RES_PCIMM  = 3'b100;

  // Memory access width from func3: 00 word, 01 half, 10 byte.
  function automatic logic [1:0] data_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic func3_illegal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD:   return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE:  return (f3 >= 3'b011);
      OP_BRANCH: return (f3 == 3'b010) || (f3 == 3'b011);
      OP_JALR:   return (f3 != 3'b000);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from ALU flags after rs1-rs2; carry set means no borrow.
module branch_resolve (
  input  logic [2:0] func3,
  input  logic       zero_flag,
  input  logic       negative_flag,
  input  logic       carry_flag,
  input  logic       overflow_flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = zero_flag;
      3'b001:  taken = ~zero_flag;
      3'b100:  taken = negative_flag ^ overflow_flag;
      3'b101:  taken = ~(negative_flag ^ overflow_flag);
      3'b110:  taken = ~carry_flag;
      3'b111:  taken = carry_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control: sequences FETCH/DECODE/EXECUTE/MEM/WB and drives
// the shared-datapath strobes, with memory ready handshake, bus timeout and trap.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE  = 1'b1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit TRAP_ENABLE    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       ZeroFlag,
  input  logic       NegativeFlag,
  input  logic       CarryFlag,
  input  logic       OverflowFlag,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [2:0] ImmSrc,
  output logic [2:0] ResultSrc,
  output logic       DataType,
  output logic [1:0] DataSize,
  output logic       illegal,
  output logic       bus_timeout,
  output logic [3:0] state_o
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_timeout_q, bus_timeout_d;

  logic       taken;
  logic       mem_state;
  logic       timeout_hit;
  logic       done;
  state_t     bad_state;

  logic       pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, data_type;
  logic [1:0] alu_src_a, alu_src_b, alu_op, data_size_c;
  logic [2:0] imm_src, result_src;

  branch_resolve u_branch_resolve (
    .func3         (func3),
    .zero_flag     (ZeroFlag),
    .negative_flag (NegativeFlag),
    .carry_flag    (CarryFlag),
    .overflow_flag (OverflowFlag),
    .taken         (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_q        <= 8'd0;
      illegal_q     <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      illegal_q     <= illegal_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = 8'd0;
    bus_timeout_d = bus_timeout_q;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    data_type     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    data_size_c   = 2'b00;
    imm_src       = IMM_I;
    result_src    = RES_ALUOUT;
    bad_state     = TRAP_ENABLE ? S_TRAP : S_FETCH;

    // mem_ready only matters in the three states that own the memory port.
    mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout_hit = mem_state && (TIMEOUT_LIM != 8'd0) && (wait_q == TIMEOUT_LIM);
    done        = (MEM_HANDSHAKE ? mem_ready : 1'b1) || timeout_hit;

    if (mem_state && !done) begin
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end
    if (timeout_hit) begin
      bus_timeout_d = 1'b1;
    end

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = bad_state;
        endcase
        if (func3_illegal(op, func3)) begin
          state_d = bad_state;
        end
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read    = 1'b1;
        adr_src     = 1'b1;
        data_type   = func3[2];
        data_size_c = data_size(func3);
        if (done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write   = 1'b1;
        result_src  = RES_MEM;
        data_type   = func3[2];
        data_size_c = data_size(func3);
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write   = 1'b1;
        adr_src     = 1'b1;
        data_size_c = data_size(func3);
        if (done) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        result_src = RES_PC4;
        pc_write   = 1'b1;
        imm_src    = IMM_J;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        reg_write  = 1'b1;
        result_src = RES_PC4;
        pc_write   = 1'b1;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        reg_write  = 1'b1;
        result_src = RES_IMM;
        imm_src    = IMM_U;
        state_d    = S_FETCH;
      end
      S_AUIPC: begin
        reg_write  = 1'b1;
        result_src = RES_PCIMM;
        imm_src    = IMM_U;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    illegal_d = (state_d == S_TRAP);
  end

  // Everything is forced low while reset is held, including the stale state register.
  assign PCWrite     = pc_write & ~reset;
  assign AdrSrc      = adr_src & ~reset;
  assign IRWrite     = ir_write & ~reset;
  assign MemRead     = mem_read & ~reset;
  assign MemWrite    = mem_write & ~reset;
  assign RegWrite    = reg_write & ~reset;
  assign ALUSrcA     = reset ? 2'b00 : alu_src_a;
  assign ALUSrcB     = reset ? 2'b00 : alu_src_b;
  assign ALUop       = reset ? 2'b00 : alu_op;
  assign ImmSrc      = reset ? 3'b000 : imm_src;
  assign ResultSrc   = reset ? 3'b000 : result_src;
  assign DataType    = data_type & ~reset;
  assign DataSize    = reset ? 2'b00 : data_size_c;
  assign illegal     = illegal_q & ~reset;
  assign bus_timeout = bus_timeout_q & ~reset;
  assign state_o     = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm: default, no-trap and short-timeout
// instances share one stimulus stream; expected strobes are hand-built constants.
module tb_multicycle_control_fsm;
  import ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] func3;
  logic [3:0] flags;  // {Z, N, C, V}
  logic       mem_ready;

  logic [20:0] m_vec, nt_vec, to_vec;
  logic [3:0]  m_state, nt_state, to_state;
  logic        m_ill, nt_ill, to_ill;
  logic        m_bto, nt_bto, to_bto;

  int checks = 0;
  int errors = 0;

  logic [20:0] v_zero, v_fetch, v_fetch_wait, v_decode, v_execr, v_aluwb;
  logic [20:0] v_memadr_l, v_memadr_s, v_lbu_rd, v_lbu_wb, v_lw_rd, v_sh_wr, v_br_t, v_br_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .func3(func3),
    .ZeroFlag(flags[3]), .NegativeFlag(flags[2]), .CarryFlag(flags[1]), .OverflowFlag(flags[0]),
    .mem_ready(mem_ready),
    .PCWrite(m_vec[20]), .AdrSrc(m_vec[19]), .IRWrite(m_vec[18]), .MemRead(m_vec[17]),
    .MemWrite(m_vec[16]), .RegWrite(m_vec[15]), .ALUSrcA(m_vec[14:13]), .ALUSrcB(m_vec[12:11]),
    .ALUop(m_vec[10:9]), .ImmSrc(m_vec[8:6]), .ResultSrc(m_vec[5:3]), .DataType(m_vec[2]),
    .DataSize(m_vec[1:0]), .illegal(m_ill), .bus_timeout(m_bto), .state_o(m_state)
  );

  multicycle_control_fsm #(.TRAP_ENABLE(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .op(op), .func3(func3),
    .ZeroFlag(flags[3]), .NegativeFlag(flags[2]), .CarryFlag(flags[1]), .OverflowFlag(flags[0]),
    .mem_ready(mem_ready),
    .PCWrite(nt_vec[20]), .AdrSrc(nt_vec[19]), .IRWrite(nt_vec[18]), .MemRead(nt_vec[17]),
    .MemWrite(nt_vec[16]), .RegWrite(nt_vec[15]), .ALUSrcA(nt_vec[14:13]), .ALUSrcB(nt_vec[12:11]),
    .ALUop(nt_vec[10:9]), .ImmSrc(nt_vec[8:6]), .ResultSrc(nt_vec[5:3]), .DataType(nt_vec[2]),
    .DataSize(nt_vec[1:0]), .illegal(nt_ill), .bus_timeout(nt_bto), .state_o(nt_state)
  );

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .op(op), .func3(func3),
    .ZeroFlag(flags[3]), .NegativeFlag(flags[2]), .CarryFlag(flags[1]), .OverflowFlag(flags[0]),
    .mem_ready(mem_ready),
    .PCWrite(to_vec[20]), .AdrSrc(to_vec[19]), .IRWrite(to_vec[18]), .MemRead(to_vec[17]),
    .MemWrite(to_vec[16]), .RegWrite(to_vec[15]), .ALUSrcA(to_vec[14:13]), .ALUSrcB(to_vec[12:11]),
    .ALUop(to_vec[10:9]), .ImmSrc(to_vec[8:6]), .ResultSrc(to_vec[5:3]), .DataType(to_vec[2]),
    .DataSize(to_vec[1:0]), .illegal(to_ill), .bus_timeout(to_bto), .state_o(to_state)
  );

  function automatic logic [20:0] mk(input logic pcw, input logic adr, input logic irw,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop, input logic [2:0] imm,
                                     input logic [2:0] res, input logic dt,
                                     input logic [1:0] ds);
    return {pcw, adr, irw, mr, mw, rw, a, b, aop, imm, res, dt, ds};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                               input logic [3:0] fl, input logic rdy);
    reset     = rst;
    op        = o;
    func3     = f3;
    flags     = fl;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] exp_state,
                            input logic [20:0] exp_vec);
    checkOutput({tag, "_state"}, 32'(m_state), 32'(exp_state));
    checkOutput({tag, "_strobes"}, 32'(m_vec), 32'(exp_vec));
  endtask

  task automatic runBranch(input string tag, input logic [2:0] f3, input logic [3:0] fl,
                           input logic exp_taken);
    applyStimulus(1'b0, OP_BRANCH, f3, fl, 1'b1);
    checkCycle({tag, "_fetch"}, S_FETCH, v_fetch);
    tick();
    checkCycle({tag, "_decode"}, S_DECODE, v_decode);
    tick();
    checkCycle({tag, "_branch"}, S_BRANCH, exp_taken ? v_br_t : v_br_n);
    tick();
  endtask

  initial begin
    v_zero       = '0;
    v_fetch      = mk(1, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    v_fetch_wait = mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    v_decode     = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 3'b000, 0, 2'b00);
    v_execr      = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 2'b00);
    v_aluwb      = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    v_memadr_l   = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    v_memadr_s   = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 0, 2'b00);
    v_lbu_rd     = mk(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 2'b10);
    v_lbu_wb     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1, 2'b10);
    v_lw_rd      = mk(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    v_sh_wr      = mk(0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b01);
    v_br_t       = mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 3'b000, 3'b000, 0, 2'b00);
    v_br_n       = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 3'b000, 3'b000, 0, 2'b00);

    // Reset: everything low.
    applyStimulus(1'b1, 7'd0, 3'd0, 4'd0, 1'b1);
    tick();
    checkCycle("reset", 4'd0, v_zero);
    checkOutput("reset_illegal", 32'(m_ill), 32'd0);
    checkOutput("reset_bus_timeout", 32'(m_bto), 32'd0);

    // add: FETCH, DECODE, EXECR, ALUWB.
    applyStimulus(1'b0, OP_RTYPE, 3'b000, 4'd0, 1'b1);
    checkCycle("add_fetch", S_FETCH, v_fetch);
    tick();
    checkCycle("add_decode", S_DECODE, v_decode);
    tick();
    checkCycle("add_execr", S_EXECR, v_execr);
    tick();
    checkCycle("add_aluwb", S_ALUWB, v_aluwb);
    tick();

    // lbu with three wait cycles in MEMREAD: 8 cycles total.
    applyStimulus(1'b0, OP_LOAD, 3'b100, 4'd0, 1'b1);
    checkCycle("lbu_fetch", S_FETCH, v_fetch);
    tick();
    checkCycle("lbu_decode", S_DECODE, v_decode);
    tick();
    checkCycle("lbu_memadr", S_MEMADR, v_memadr_l);
    tick();
    applyStimulus(1'b0, OP_LOAD, 3'b100, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkCycle("lbu_memread_wait", S_MEMREAD, v_lbu_rd);
      tick();
    end
    applyStimulus(1'b0, OP_LOAD, 3'b100, 4'd0, 1'b1);
    checkCycle("lbu_memread_done", S_MEMREAD, v_lbu_rd);
    tick();
    checkCycle("lbu_memwb", S_MEMWB, v_lbu_wb);
    tick();

    // sh: FETCH, DECODE, MEMADR, MEMWRITE.
    applyStimulus(1'b0, OP_STORE, 3'b001, 4'd0, 1'b1);
    checkCycle("sh_fetch", S_FETCH, v_fetch);
    tick();
    checkCycle("sh_decode", S_DECODE, v_decode);
    tick();
    checkCycle("sh_memadr", S_MEMADR, v_memadr_s);
    tick();
    checkCycle("sh_memwrite", S_MEMWRITE, v_sh_wr);
    tick();

    // Branches, flags are {Z, N, C, V}.
    runBranch("bltu_c0", 3'b110, 4'b0000, 1'b1);
    runBranch("bltu_c1", 3'b110, 4'b0010, 1'b0);
    runBranch("bge_n1v1", 3'b101, 4'b0101, 1'b1);
    runBranch("bge_n1v0", 3'b101, 4'b0100, 1'b0);
    runBranch("beq_z1", 3'b000, 4'b1000, 1'b1);
    runBranch("bne_z1", 3'b001, 4'b1000, 1'b0);

    // Unknown opcode: TRAP in the default build, straight back to FETCH without trap.
    applyStimulus(1'b0, 7'b1111111, 3'b000, 4'd0, 1'b1);
    checkCycle("badop_fetch", S_FETCH, v_fetch);
    tick();
    checkCycle("badop_decode", S_DECODE, v_decode);
    tick();
    checkCycle("badop_trap", S_TRAP, v_zero);
    checkOutput("badop_illegal", 32'(m_ill), 32'd1);
    checkOutput("notrap_state", 32'(nt_state), 32'(S_FETCH));
    checkOutput("notrap_illegal", 32'(nt_ill), 32'd0);
    checkOutput("notrap_strobes", 32'(nt_vec), 32'(v_fetch));
    tick();
    tick();
    tick();
    checkCycle("badop_trap_hold", S_TRAP, v_zero);
    checkOutput("badop_illegal_hold", 32'(m_ill), 32'd1);

    applyStimulus(1'b1, 7'd0, 3'd0, 4'd0, 1'b1);
    checkOutput("trap_reset_illegal", 32'(m_ill), 32'd0);
    checkCycle("trap_reset", 4'd0, v_zero);
    tick();

    // Legal opcode with illegal func3 (load f3=011).
    applyStimulus(1'b0, OP_LOAD, 3'b011, 4'd0, 1'b1);
    tick();
    checkCycle("badf3_decode", S_DECODE, v_decode);
    tick();
    checkCycle("badf3_trap", S_TRAP, v_zero);
    checkOutput("badf3_illegal", 32'(m_ill), 32'd1);
    applyStimulus(1'b1, 7'd0, 3'd0, 4'd0, 1'b1);
    tick();

    // Reset while stalled in MEMREAD.
    applyStimulus(1'b0, OP_LOAD, 3'b010, 4'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, OP_LOAD, 3'b010, 4'd0, 1'b0);
    tick();
    checkCycle("lw_memread_stall", S_MEMREAD, v_lw_rd);
    tick();
    applyStimulus(1'b1, OP_LOAD, 3'b010, 4'd0, 1'b0);
    checkCycle("midread_reset", 4'd0, v_zero);
    tick();
    applyStimulus(1'b0, OP_LOAD, 3'b010, 4'd0, 1'b0);
    checkCycle("midread_after_reset", S_FETCH, v_fetch_wait);

    // Stuck mem_ready in FETCH on the 4-cycle timeout build.
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_fetch_wait_state", 32'(to_state), 32'(S_FETCH));
      checkOutput("to_fetch_wait_bto", 32'(to_bto), 32'd0);
      tick();
    end
    checkOutput("to_forced_done_strobes", 32'(to_vec), 32'(v_fetch));
    tick();
    checkOutput("to_advance_state", 32'(to_state), 32'(S_DECODE));
    checkOutput("to_bto_set", 32'(to_bto), 32'd1);
    checkOutput("to_default_no_bto", 32'(m_bto), 32'd0);
    applyStimulus(1'b0, OP_LOAD, 3'b010, 4'd0, 1'b1);
    tick();
    tick();
    checkOutput("to_bto_sticky", 32'(to_bto), 32'd1);
    applyStimulus(1'b1, 7'd0, 3'd0, 4'd0, 1'b1);
    tick();
    checkOutput("to_bto_reset", 32'(to_bto), 32'd0);
    applyStimulus(1'b0, 7'd0, 3'd0, 4'd0, 1'b1);
    checkOutput("to_bto_after_reset", 32'(to_bto), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
